uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_DIV, default 25, sets sys_clk cycles per bit (legal >= 8).
REQ-002 Parameter DATA_BITS, default 8, sets data bits per frame (legal 5..8).
REQ-003 Parameter PARITY_MODE, default 0, selects parity: 0 none, 1 odd, 2 even.
REQ-004 Parameter FIFO_DEPTH, default 4, sets receive FIFO words (power of 2, legal 2..16).
REQ-005 sys_clk  input  1  single clock; all logic rising-edge.
REQ-006 sys_rst  input  1  reset; asynchronous, active-high.
REQ-007 uart_rxd  input  1  serial line, idle high, asynchronous to sys_clk.
REQ-008 rx_data  output  DATA_BITS  head-of-FIFO data word.
REQ-009 rx_parity_err  output  1  head word had parity mismatch.
REQ-010 rx_frame_err  output  1  head word had low stop bit.
REQ-011 rx_valid  output  1  FIFO non-empty; head word and flags valid.
REQ-012 rx_ready  input  1  consumer accepts head word.
REQ-013 rx_overrun  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-014 uart_rxd SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START on synchronized falling edge (previous 1, current 0); bit counter cleared.
REQ-017 Bit timing: counter runs 0..CLK_DIV-1 per bit; mid-bit point is CLK_DIV/2 (integer division).
REQ-018 Each bit value SHALL be 2-of-3 majority of samples at mid-1, mid, mid+1.
REQ-019 START: majority at mid-bit high -> IDLE without push (glitch reject); low -> DATA.
REQ-020 DATA: DATA_BITS bits, LSB first, shifted into data register.
REQ-021 After last data bit: PARITY if PARITY_MODE != 0, else STOP.
REQ-022 PARITY: parity_err = (XOR of data bits XOR received bit) != (PARITY_MODE==1).
REQ-023 STOP: after majority decided at mid+1, frame_err = NOT stop-bit; word, parity_err, frame_err pushed same cycle; FSM -> IDLE that cycle.
REQ-024 Return to IDLE at mid-stop SHALL allow a back-to-back next start bit to be detected.
REQ-025 A frame with frame_err SHALL still be pushed (flag set); if line stays low, no new start until it goes high then falls.
REQ-026 FIFO is first-word-fall-through: push into empty FIFO -> rx_valid high next cycle with data.
REQ-027 Pop occurs iff rx_valid & rx_ready; next word (or rx_valid low) visible next cycle.
REQ-028 Push when full: word dropped, rx_overrun pulses 1 cycle, FIFO contents unchanged.
REQ-029 Simultaneous push and pop when full: pop then push; no overrun.
REQ-030 rx_ready while rx_valid low SHALL have no effect.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty via extra pointer MSB.
REQ-032 rx_data, error flags SHALL be 0 whenever rx_valid is low.

Reset
REQ-033 On sys_rst high: FSM IDLE, counters 0, synchronizer flops 1, FIFO empty, rx_valid 0, rx_data 0, flags 0, rx_overrun 0.
REQ-034 Reset mid-frame SHALL discard the partial frame; after release, reception resumes at next falling edge.

Structure
REQ-035 Package uart_pkg SHALL hold PARITY_NONE/ODD/EVEN constants and FSM state encoding.
REQ-036 FIFO SHALL be sub-module uart_rx_fifo (width DATA_BITS+2, depth FIFO_DEPTH, FWFT, full/empty, overrun pulse).

Verification
REQ-037 Defaults, frame 0x55 with stop high, rx_ready=1 -> one rx_valid cycle, rx_data=0x55, both flags 0.
REQ-038 Line low 5 cycles then high, CLK_DIV=25 -> no push, rx_valid stays 0, FSM back to IDLE.
REQ-039 PARITY_MODE=2, data 0xA3 with parity bit 1 (wrong) -> rx_data=0xA3, rx_parity_err=1; correct bit 0 -> flag 0.
REQ-040 Frame 0x3C with stop bit low -> rx_data=0x3C, rx_frame_err=1; no new word until line returns high.
REQ-041 FIFO_DEPTH=4, rx_ready=0, 5 frames 0x01..0x05 -> 4 words, one rx_overrun pulse; rx_ready=1 drains 0x01..0x04 in order.
REQ-042 sys_rst asserted during data bit 4 of a frame -> outputs reset values, no word pushed; next full frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive slice: parity mode codes, the
// receiver FSM encoding and the 2-of-3 majority vote used for bit sampling.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO is dropped and
// reported with a one-cycle overrun pulse unless a pop frees the slot that cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             overrun_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             overrun_q, overrun_d;
    logic             empty, full;
    logic             do_pop, do_push;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        overrun_d = push_i & full & ~do_pop;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign valid_o   = ~empty;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: synchronised line, majority-voted mid-bit
// sampling, optional parity, and a FWFT word FIFO carrying per-word error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);

    localparam int CW  = $clog2(CLK_DIV);
    localparam int MID = CLK_DIV / 2;
    localparam int FW  = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic          ODD_SEL  = (PARITY_MODE == PARITY_ODD);
    localparam logic          HAS_PAR  = (PARITY_MODE != PARITY_NONE);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic                 rxd_s;
    logic                 maj;
    logic                 decide;
    logic                 bit_end;
    logic                 push;
    logic                 frame_err;
    logic [FW-1:0]        fifo_wdata;
    logic [FW-1:0]        fifo_rdata;

    // Synchroniser and edge history idle high so reset never fakes a start edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rxd_s   = sync2_q;
    assign maj     = majority3(samp_q[0], samp_q[1], rxd_s);
    assign decide  = (cnt_q == CNT_DEC);
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        samp_d    = samp_q;
        data_d    = data_q;
        perr_d    = perr_q;
        push      = 1'b0;
        frame_err = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0) begin
                samp_d[0] = rxd_s;
            end
            if (cnt_q == CNT_S1) begin
                samp_d[1] = rxd_s;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !rxd_s) begin
                    state_d = START;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            START: begin
                // A start bit that votes high at mid-bit was a glitch.
                if (decide && maj) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    data_d = {maj, data_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = HAS_PAR ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    perr_d = ((^data_q) ^ maj) != ODD_SEL;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop gives a back-to-back start bit a clean edge.
                if (decide) begin
                    push      = 1'b1;
                    frame_err = ~maj;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    assign fifo_wdata = {frame_err, perr_q, data_q};

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .push_i    (push),
        .wdata_i   (fifo_wdata),
        .pop_i     (rx_ready),
        .rdata_o   (fifo_rdata),
        .valid_o   (rx_valid),
        .overrun_o (rx_overrun)
    );

    assign {rx_frame_err, rx_parity_err, rx_data} = fifo_rdata;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one no-parity instance and one even-parity
// instance, each on its own serial line, checked against hand-computed words.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int CLK_DIV = 25;

    logic       sysClk = 1'b0;
    logic       sysRst = 1'b1;
    logic       rxdA   = 1'b1;
    logic       rxdP   = 1'b1;
    logic       readyA = 1'b1;
    logic       readyP = 1'b1;
    logic [7:0] dataA, dataP;
    logic       perrA, ferrA, validA, overrunA;
    logic       perrP, ferrP, validP, overrunP;

    logic [9:0] wordsA [$];
    logic [9:0] wordsP [$];
    int         validCyclesA = 0;
    int         overrunsA    = 0;
    int         overrunsP    = 0;
    int         zeroBad      = 0;
    int         checksTotal  = 0;
    int         checksPassed = 0;
    int         snapValid;

    always #5 sysClk = ~sysClk;

    uart_rx_param #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4)
    ) dutA (
        .sys_clk(sysClk), .sys_rst(sysRst), .uart_rxd(rxdA),
        .rx_data(dataA), .rx_parity_err(perrA), .rx_frame_err(ferrA),
        .rx_valid(validA), .rx_ready(readyA), .rx_overrun(overrunA)
    );

    uart_rx_param #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_MODE(2), .FIFO_DEPTH(4)
    ) dutP (
        .sys_clk(sysClk), .sys_rst(sysRst), .uart_rxd(rxdP),
        .rx_data(dataP), .rx_parity_err(perrP), .rx_frame_err(ferrP),
        .rx_valid(validP), .rx_ready(readyP), .rx_overrun(overrunP)
    );

    // Record every accepted word as {frame_err, parity_err, data}.
    always @(negedge sysClk) begin
        if (validA) validCyclesA++;
        if (validA && readyA) wordsA.push_back({ferrA, perrA, dataA});
        if (validP && readyP) wordsP.push_back({ferrP, perrP, dataP});
        if (overrunA) overrunsA++;
        if (overrunP) overrunsP++;
        if (!validA && (dataA != 8'h00 || perrA || ferrA)) zeroBad++;
        if (!validP && (dataP != 8'h00 || perrP || ferrP)) zeroBad++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    task automatic driveBit(input bit sel, input bit v);
        if (sel) rxdP = v;
        else     rxdA = v;
        idle(CLK_DIV);
    endtask

    // Sends one frame on line A (sel=0) or line P (sel=1); line is left at the stop level.
    task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit usePar,
                                 input bit parBit, input bit stopBit);
        driveBit(sel, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(sel, data[i]);
        if (usePar) driveBit(sel, parBit);
        driveBit(sel, stopBit);
    endtask

    function automatic logic [9:0] popA();
        if (wordsA.size() == 0) return 10'h3FF;
        return wordsA.pop_front();
    endfunction

    function automatic logic [9:0] popP();
        if (wordsP.size() == 0) return 10'h3FF;
        return wordsP.pop_front();
    endfunction

    initial begin
        idle(3);
        checkOutput("rstValid", {31'd0, validA}, 32'd0);
        checkOutput("rstData", {24'd0, dataA}, 32'd0);
        checkOutput("rstFlags", {30'd0, perrA, ferrA}, 32'd0);
        checkOutput("rstOverrun", {31'd0, overrunA}, 32'd0);
        checkOutput("rstState", 32'(dutA.state_q), 32'(IDLE));
        sysRst = 1'b0;
        idle(10);

        $display("[TB] basic frame 0x55");
        snapValid = validCyclesA;
        applyStimulus(0, 8'h55, 0, 0, 1);
        idle(10);
        checkOutput("basicCount", wordsA.size(), 32'd1);
        checkOutput("basicWord", {22'd0, popA()}, 32'h055);
        checkOutput("basicValidCycles", validCyclesA - snapValid, 32'd1);

        $display("[TB] start glitch");
        snapValid = validCyclesA;
        rxdA = 1'b0;
        idle(5);
        rxdA = 1'b1;
        idle(40);
        checkOutput("glitchCount", wordsA.size(), 32'd0);
        checkOutput("glitchValid", validCyclesA - snapValid, 32'd0);
        checkOutput("glitchState", 32'(dutA.state_q), 32'(IDLE));

        $display("[TB] even parity 0xA3");
        applyStimulus(1, 8'hA3, 1, 1, 1);
        idle(10);
        checkOutput("parBadWord", {22'd0, popP()}, 32'h1A3);
        applyStimulus(1, 8'hA3, 1, 0, 1);
        idle(10);
        checkOutput("parGoodWord", {22'd0, popP()}, 32'h0A3);

        $display("[TB] framing error 0x3C");
        applyStimulus(0, 8'h3C, 0, 0, 0);
        idle(60);
        checkOutput("frameCount", wordsA.size(), 32'd1);
        checkOutput("frameWord", {22'd0, popA()}, 32'h23C);
        rxdA = 1'b1;
        idle(30);
        checkOutput("frameNoExtra", wordsA.size(), 32'd0);
        applyStimulus(0, 8'h5A, 0, 0, 1);
        idle(10);
        checkOutput("frameRecover", {22'd0, popA()}, 32'h05A);

        $display("[TB] fifo overrun");
        readyA = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), 0, 0, 1);
        idle(5);
        checkOutput("ovrPulses", overrunsA, 32'd1);
        checkOutput("ovrHeld", {31'd0, validA}, 32'd1);
        checkOutput("ovrHead", {24'd0, dataA}, 32'h01);
        readyA = 1'b1;
        idle(10);
        checkOutput("ovrDrainCount", wordsA.size(), 32'd4);
        for (int i = 1; i <= 4; i++) checkOutput($sformatf("ovrDrain%0d", i), {22'd0, popA()}, 32'(i));
        checkOutput("ovrEmpty", {31'd0, validA}, 32'd0);

        $display("[TB] reset mid-frame");
        readyA = 1'b0;
        applyStimulus(0, 8'h11, 0, 0, 1);
        idle(5);
        checkOutput("preRstValid", {31'd0, validA}, 32'd1);
        driveBit(0, 1'b0);
        driveBit(0, 1'b0);
        driveBit(0, 1'b1);
        driveBit(0, 1'b1);
        driveBit(0, 1'b1);
        rxdA = 1'b1;
        idle(12);
        sysRst = 1'b1;
        idle(3);
        checkOutput("midRstValid", {31'd0, validA}, 32'd0);
        checkOutput("midRstData", {24'd0, dataA}, 32'd0);
        checkOutput("midRstState", 32'(dutA.state_q), 32'(IDLE));
        sysRst = 1'b0;
        readyA = 1'b1;
        idle(40);
        checkOutput("postRstCount", wordsA.size(), 32'd0);
        applyStimulus(0, 8'h7E, 0, 0, 1);
        idle(10);
        checkOutput("postRstWord", {22'd0, popA()}, 32'h07E);

        checkOutput("totalOverrunsA", overrunsA, 32'd1);
        checkOutput("totalOverrunsP", overrunsP, 32'd0);
        checkOutput("zeroWhenInvalid", zeroBad, 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
